traffic_light_monitor: RTL and testbench

Passive checker that samples the six lamp outputs of the two-direction traffic light controller (r0/y0/g0, r1/y1/g1) and flags protocol violations: illegal lamp encodings, cross-direction conflicts, out-of-order phases and short green/yellow dwell. It sits beside the controller on the same clock, on the receiving end of the lamp interface, in both the FPGA build and the bench. It reports the first fault with a sticky flag and code, and pulses a per-direction completion strobe for each clean G→Y→R cycle.

---
 rtl/traffic_pkg.sv | 49 ++++
 rtl/light_dir_mon.sv | 112 +++++++++++
 rtl/traffic_light_monitor.sv | 133 +++++++++++++
 tb/tb_traffic_light_monitor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared lamp-phase and fault-code definitions for the
// traffic light controller, its monitor and the bench.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_UNK = 2'b00,
    PH_RED = 2'b01,
    PH_GRN = 2'b10,
    PH_YEL = 2'b11
  } phase_e;

  localparam logic [2:0] FC_NONE = 3'd0;
  localparam logic [2:0] FC_ENC  = 3'd1;
  localparam logic [2:0] FC_CONF = 3'd2;
  localparam logic [2:0] FC_SEQ  = 3'd3;
  localparam logic [2:0] FC_SGRN = 3'd4;
  localparam logic [2:0] FC_SYEL = 3'd5;

  // One-hot lamp sample to phase; anything else is UNK.
  function automatic phase_e lamp_decode(
    input logic r,
    input logic y,
    input logic g
  );
    phase_e p;
    p = PH_UNK;
    unique case ({r, y, g})
      3'b100:  p = PH_RED;
      3'b001:  p = PH_GRN;
      3'b010:  p = PH_YEL;
      default: p = PH_UNK;
    endcase
    return p;
  endfunction

  // The only phase a direction may legally move to next.
  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    n = PH_UNK;
    unique case (p)
      PH_RED:  n = PH_GRN;
      PH_GRN:  n = PH_YEL;
      PH_YEL:  n = PH_RED;
      default: n = PH_UNK;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/light_dir_mon.sv
// One direction of the lamp monitor: decode, phase FSM,
// dwell counter, fault candidates and completion strobe.
module light_dir_mon
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int CNT_W      = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   r_i,
  input  logic   y_i,
  input  logic   g_i,
  output phase_e phase_o,
  output phase_e samp_o,
  output logic   enc_o,
  output logic   seq_o,
  output logic   sg_o,
  output logic   sy_o,
  output logic   done_o
);

  localparam logic [CNT_W-1:0] MG  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MY  = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  phase_e           phase_q, phase_d;
  phase_e           samp;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             part_q, part_d;
  logic             gfull_q, gfull_d;
  logic             done_q, done_d;
  logic             enc, seq, sg, sy;

  // Phase tracking: partial phases skip dwell checks;
  // gfull remembers that the current yellow followed a
  // fully observed green.
  always_comb begin
    samp    = lamp_decode(r_i, y_i, g_i);
    phase_d = phase_q;
    dwell_d = dwell_q;
    part_d  = part_q;
    gfull_d = gfull_q;
    done_d  = 1'b0;
    enc     = 1'b0;
    seq     = 1'b0;
    sg      = 1'b0;
    sy      = 1'b0;
    if (samp == PH_UNK) begin
      enc     = 1'b1;
      phase_d = PH_UNK;
      dwell_d = '0;
      part_d  = 1'b1;
      gfull_d = 1'b0;
    end else if (phase_q == PH_UNK) begin
      phase_d = samp;
      dwell_d = ONE;
      part_d  = 1'b1;
      gfull_d = 1'b0;
    end else if (samp == phase_q) begin
      if (dwell_q != MAX)
        dwell_d = dwell_q + 1'b1;
    end else if (samp == next_phase(phase_q)) begin
      phase_d = samp;
      dwell_d = ONE;
      part_d  = 1'b0;
      gfull_d = 1'b0;
      if (phase_q == PH_GRN) begin
        sg      = !part_q && (dwell_q < MG);
        gfull_d = !part_q;
      end
      if (phase_q == PH_YEL) begin
        sy     = !part_q && (dwell_q < MY);
        done_d = !sy && !part_q && gfull_q;
      end
    end else begin
      seq     = 1'b1;
      phase_d = samp;
      dwell_d = ONE;
      part_d  = 1'b1;
      gfull_d = 1'b0;
    end
  end

  // State register; reset discards all tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_UNK;
      dwell_q <= '0;
      part_q  <= 1'b1;
      gfull_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      part_q  <= part_d;
      gfull_q <= gfull_d;
      done_q  <= done_d;
    end
  end

  assign phase_o = phase_q;
  assign samp_o  = samp;
  assign enc_o   = enc;
  assign seq_o   = seq;
  assign sg_o    = sg;
  assign sy_o    = sy;
  assign done_o  = done_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Two-direction lamp protocol monitor: conflict check,
// fault priority and sticky first-fault capture.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       r0,
  input  logic       y0,
  input  logic       g0,
  input  logic       r1,
  input  logic       y1,
  input  logic       g1,
  output logic [1:0] phase0,
  output logic [1:0] phase1,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       fault_dir,
  output logic       done0,
  output logic       done1
);

  phase_e     ph0, ph1, s0, s1;
  logic       enc0, seq0, sg0, sy0;
  logic       enc1, seq1, sg1, sy1;
  logic       conf;
  logic       new_f;
  logic [2:0] new_code;
  logic       new_dir;
  logic       fault_q, fault_d;
  logic [2:0] code_q, code_d;
  logic       dir_q, dir_d;

  light_dir_mon #(
    .MIN_GREEN (MIN_GREEN),
    .MIN_YELLOW(MIN_YELLOW),
    .CNT_W     (CNT_W)
  ) u_dir0 (
    .clk    (clk),
    .rst    (rst),
    .r_i    (r0),
    .y_i    (y0),
    .g_i    (g0),
    .phase_o(ph0),
    .samp_o (s0),
    .enc_o  (enc0),
    .seq_o  (seq0),
    .sg_o   (sg0),
    .sy_o   (sy0),
    .done_o (done0)
  );

  light_dir_mon #(
    .MIN_GREEN (MIN_GREEN),
    .MIN_YELLOW(MIN_YELLOW),
    .CNT_W     (CNT_W)
  ) u_dir1 (
    .clk    (clk),
    .rst    (rst),
    .r_i    (r1),
    .y_i    (y1),
    .g_i    (g1),
    .phase_o(ph1),
    .samp_o (s1),
    .enc_o  (enc1),
    .seq_o  (seq1),
    .sg_o   (sg1),
    .sy_o   (sy1),
    .done_o (done1)
  );

  assign conf = (s0 != PH_UNK) && (s1 != PH_UNK)
             && (s0 != PH_RED) && (s1 != PH_RED);

  // Lowest code wins; direction 0 wins a tie.
  always_comb begin
    new_f    = 1'b1;
    new_code = FC_NONE;
    new_dir  = 1'b0;
    if (enc0)      new_code = FC_ENC;
    else if (enc1) begin new_code = FC_ENC;  new_dir = 1'b1; end
    else if (conf) new_code = FC_CONF;
    else if (seq0) new_code = FC_SEQ;
    else if (seq1) begin new_code = FC_SEQ;  new_dir = 1'b1; end
    else if (sg0)  new_code = FC_SGRN;
    else if (sg1)  begin new_code = FC_SGRN; new_dir = 1'b1; end
    else if (sy0)  new_code = FC_SYEL;
    else if (sy1)  begin new_code = FC_SYEL; new_dir = 1'b1; end
    else           new_f = 1'b0;
  end

  // Clear first, then a fault this cycle can still latch.
  always_comb begin
    fault_d = fault_q;
    code_d  = code_q;
    dir_d   = dir_q;
    if (clr) begin
      fault_d = 1'b0;
      code_d  = FC_NONE;
      dir_d   = 1'b0;
    end
    if (!fault_d && new_f) begin
      fault_d = 1'b1;
      code_d  = new_code;
      dir_d   = new_dir;
    end
  end

  // Sticky first-fault registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      dir_q   <= 1'b0;
    end else begin
      fault_q <= fault_d;
      code_q  <= code_d;
      dir_q   <= dir_d;
    end
  end

  assign phase0     = ph0;
  assign phase1     = ph1;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign fault_dir  = dir_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scenario bench for traffic_light_monitor: expected
// outputs queued per sample, compared per scenario.
module tb_traffic_light_monitor;

  typedef struct packed {
    logic [1:0] p0;
    logic [1:0] p1;
    logic       f;
    logic [2:0] code;
    logic       dir;
    logic       d0;
    logic       d1;
  } out_t;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       r0 = 1'b0, y0 = 1'b0, g0 = 1'b0;
  logic       r1 = 1'b0, y1 = 1'b0, g1 = 1'b0;
  logic [1:0] phase0, phase1;
  logic       fault;
  logic [2:0] fault_code;
  logic       fault_dir;
  logic       done0, done1;

  out_t expq[$];
  out_t obsq[$];
  out_t e, o;
  int   nvec = 0;
  int   nmis = 0;

  traffic_light_monitor #(
    .MIN_GREEN (4),
    .MIN_YELLOW(2),
    .CNT_W     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .r0        (r0),
    .y0        (y0),
    .g0        (g0),
    .r1        (r1),
    .y1        (y1),
    .g1        (g1),
    .phase0    (phase0),
    .phase1    (phase1),
    .fault     (fault),
    .fault_code(fault_code),
    .fault_dir (fault_dir),
    .done0     (done0),
    .done1     (done1)
  );

  always #5 clk = ~clk;

  function automatic out_t ex(
    input logic [1:0] p0,
    input logic [1:0] p1,
    input logic       f,
    input logic [2:0] code,
    input logic       dir,
    input logic       d0,
    input logic       d1
  );
    out_t t;
    t.p0 = p0; t.p1 = p1; t.f = f; t.code = code;
    t.dir = dir; t.d0 = d0; t.d1 = d1;
    return t;
  endfunction

  // Drive one sample, queue its expectation, record
  // the outputs one cycle later.
  task automatic apply(
    input logic       rst_v,
    input logic [2:0] l0,
    input logic [2:0] l1,
    input logic       clr_v,
    input out_t       want
  );
    rst = rst_v;
    clr = clr_v;
    {r0, y0, g0} = l0;
    {r1, y1, g1} = l1;
    expq.push_back(want);
    @(posedge clk);
    #1;
    obsq.push_back({phase0, phase1, fault, fault_code,
                    fault_dir, done0, done1});
  endtask

  task automatic test_reset();
    apply(1, R, R, 0, ex(0, 0, 0, 0, 0, 0, 0));
    apply(1, 3'b101, 3'b000, 1, ex(0, 0, 0, 0, 0, 0, 0));
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); nvec++;
      if (o !== e) begin
        nmis++;
        $display("FAIL reset #%0d got %b want %b", nvec, o, e);
      end
    end
  endtask

  task automatic test_cycle();
    apply(1, R, R, 0, ex(0, 0, 0, 0, 0, 0, 0));
    repeat (3) apply(0, R, R, 0, ex(1, 1, 0, 0, 0, 0, 0));
    repeat (4) apply(0, G, R, 0, ex(2, 1, 0, 0, 0, 0, 0));
    repeat (2) apply(0, Y, R, 0, ex(3, 1, 0, 0, 0, 0, 0));
    apply(0, R, R, 0, ex(1, 1, 0, 0, 0, 1, 0));
    apply(0, R, R, 0, ex(1, 1, 0, 0, 0, 0, 0));
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); nvec++;
      if (o !== e) begin
        nmis++;
        $display("FAIL cycle #%0d got %b want %b", nvec, o, e);
      end
    end
  endtask

  task automatic test_short_green();
    apply(1, R, R, 0, ex(0, 0, 0, 0, 0, 0, 0));
    apply(0, R, R, 0, ex(1, 1, 0, 0, 0, 0, 0));
    repeat (3) apply(0, G, R, 0, ex(2, 1, 0, 0, 0, 0, 0));
    apply(0, Y, R, 0, ex(3, 1, 1, 4, 0, 0, 0));
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); nvec++;
      if (o !== e) begin
        nmis++;
        $display("FAIL short_green #%0d got %b want %b", nvec, o, e);
      end
    end
  endtask

  task automatic test_encoding();
    apply(1, R, R, 0, ex(0, 0, 0, 0, 0, 0, 0));
    apply(0, R, R, 0, ex(1, 1, 0, 0, 0, 0, 0));
    apply(0, R, 3'b101, 0, ex(1, 0, 1, 1, 1, 0, 0));
    apply(0, R, R, 0, ex(1, 1, 1, 1, 1, 0, 0));
    apply(0, 3'b000, R, 0, ex(0, 1, 1, 1, 1, 0, 0));
    apply(0, R, R, 0, ex(1, 1, 1, 1, 1, 0, 0));
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); nvec++;
      if (o !== e) begin
        nmis++;
        $display("FAIL encoding #%0d got %b want %b", nvec, o, e);
      end
    end
  endtask

  task automatic test_conflict();
    apply(1, R, R, 0, ex(0, 0, 0, 0, 0, 0, 0));
    apply(0, Y, R, 0, ex(3, 1, 0, 0, 0, 0, 0));
    apply(0, G, Y, 0, ex(2, 3, 1, 2, 0, 0, 0));
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); nvec++;
      if (o !== e) begin
        nmis++;
        $display("FAIL conflict #%0d got %b want %b", nvec, o, e);
      end
    end
  endtask

  task automatic test_seq_clr();
    apply(1, R, R, 0, ex(0, 0, 0, 0, 0, 0, 0));
    apply(0, R, R, 0, ex(1, 1, 0, 0, 0, 0, 0));
    apply(0, R, Y, 0, ex(1, 3, 1, 3, 1, 0, 0));
    apply(0, R, Y, 1, ex(1, 3, 0, 0, 0, 0, 0));
    apply(0, R, R, 0, ex(1, 1, 0, 0, 0, 0, 0));
    repeat (4) apply(0, R, G, 0, ex(1, 2, 0, 0, 0, 0, 0));
    apply(0, R, Y, 0, ex(1, 3, 0, 0, 0, 0, 0));
    apply(0, R, R, 0, ex(1, 1, 1, 5, 1, 0, 0));
    apply(0, R, Y, 1, ex(1, 3, 1, 3, 1, 0, 0));
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); nvec++;
      if (o !== e) begin
        nmis++;
        $display("FAIL seq_clr #%0d got %b want %b", nvec, o, e);
      end
    end
  endtask

  task automatic test_rst_mid_green();
    apply(1, R, R, 0, ex(0, 0, 0, 0, 0, 0, 0));
    apply(0, R, R, 0, ex(1, 1, 0, 0, 0, 0, 0));
    repeat (2) apply(0, G, R, 0, ex(2, 1, 0, 0, 0, 0, 0));
    apply(1, G, R, 0, ex(0, 0, 0, 0, 0, 0, 0));
    apply(0, G, R, 0, ex(2, 1, 0, 0, 0, 0, 0));
    repeat (2) apply(0, Y, R, 0, ex(3, 1, 0, 0, 0, 0, 0));
    apply(0, R, R, 0, ex(1, 1, 0, 0, 0, 0, 0));
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); nvec++;
      if (o !== e) begin
        nmis++;
        $display("FAIL rst_mid_green #%0d got %b want %b", nvec, o, e);
      end
    end
  endtask

  task automatic test_saturation();
    apply(1, R, R, 0, ex(0, 0, 0, 0, 0, 0, 0));
    apply(0, R, R, 0, ex(1, 1, 0, 0, 0, 0, 0));
    repeat (258) apply(0, G, R, 0, ex(2, 1, 0, 0, 0, 0, 0));
    repeat (2) apply(0, Y, R, 0, ex(3, 1, 0, 0, 0, 0, 0));
    apply(0, R, R, 0, ex(1, 1, 0, 0, 0, 1, 0));
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); nvec++;
      if (o !== e) begin
        nmis++;
        $display("FAIL saturation #%0d got %b want %b", nvec, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply(1, R, R, 0, ex(0, 0, 0, 0, 0, 0, 0));
    apply(0, R, R, 0, ex(1, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 2; k++) begin
      repeat (4) apply(0, R, G, 0, ex(1, 2, 0, 0, 0, 0, 0));
      repeat (2) apply(0, R, Y, 0, ex(1, 3, 0, 0, 0, 0, 0));
      apply(0, R, R, 0, ex(1, 1, 0, 0, 0, 0, 1));
    end
    apply(0, R, R, 0, ex(1, 1, 0, 0, 0, 0, 0));
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); nvec++;
      if (o !== e) begin
        nmis++;
        $display("FAIL back_to_back #%0d got %b want %b", nvec, o, e);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_cycle();
    test_short_green();
    test_encoding();
    test_conflict();
    test_seq_clr();
    test_rst_mid_green();
    test_saturation();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
